pipe_if_ctrl: RTL and testbench
===============================

# pipe_if_ctrl

Fetch-stage controller for the pipelined MIPS core. It owns the PC register and the single port of the instruction RAM. It shares that port between a program loader (boot-time writes) and instruction fetch. It sequences PC updates from the next-PC mux (stall, redirect, halt) and raises the IF/ID flush for control hazards. It sits between the hazard/ID logic and the fetch datapath, driving `pc`, `ram_ena`, `ram_wena` and `ram_indata` into it and taking `npc` back.

## Interface
- `DEPTH_LOG2`, 5: instruction RAM word-address width; the RAM address is `pc[DEPTH_LOG2+1:2]`.
- `RESET_PC`, 32'h0000_0000: PC value after reset and after load completion.

- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  synchronous, active-low reset.
- `boot_req`  in  1  request to (re)load the program; sampled in IDLE and HALT.
- `ld_valid`  in  1  loader word valid.
- `ld_data`  in  32  loader instruction word.
- `ld_last`  in  1  marks the final loader word.
- `ld_ready`  out  1  controller accepts a loader word.
- `npc`  in  32  next PC from the fetch datapath.
- `pcsource`  in  2  next-PC select from ID; 2'b00 = sequential, any other value = redirect.
- `stall`  in  1  hazard unit holds PC and IF/ID.
- `halt_req`  in  1  stop fetching.
- `resume`  in  1  leave HALT.
- `pc`  out  32  PC register; also the RAM address during load.
- `ram_ena`  out  1  instruction RAM enable.
- `ram_wena`  out  1  instruction RAM write enable.
- `ram_indata`  out  32  RAM write data.
- `if_flush`  out  1  squash the IF/ID register.
- `running`  out  1  state is RUN.

## Operation
- States: IDLE, LOAD, RUN, HALT. Reset and default state is IDLE.
- IDLE:
  - `ram_ena` = `ram_wena` = 0; `pc` holds RESET_PC.
  - `boot_req` -> LOAD.
- LOAD:
  - `ld_ready` = 1.
  - Beat = `ld_valid & ld_ready`. On a beat, `ram_ena` = `ram_wena` = 1 and `ram_indata` = `ld_data`; the word is written at `pc[DEPTH_LOG2+1:2]`; then `pc` += 4.
  - Load ends on a beat with `ld_last`, or on a beat at the last word address (2^DEPTH_LOG2 - 1, wrap). At the end, `pc` <= RESET_PC and the state goes to RUN.
  - `ram_wena` never asserts outside LOAD beats.
- RUN:
  - `ram_ena` = `~stall`; `ram_wena` = 0.
  - Priority, highest first: `halt_req` > `stall` > redirect > sequential.
  - `halt_req`: go to HALT; `pc` is held.
  - `stall`: `pc` is held; `if_flush` = 0, even if `pcsource` != 0, because ID re-presents the branch next cycle.
  - Otherwise: `pc` <= `npc`.
  - Redirect (`pcsource` != 0, no stall): `if_flush` = 1 for that cycle (see Configuration).
- HALT:
  - `ram_ena` = 0; `pc` is held.
  - `resume` -> RUN.
  - `boot_req` -> LOAD, with `pc` <= RESET_PC. If both are high, `boot_req` wins.
- PC arithmetic is 32-bit modulo and is never checked for range. In RUN, `npc` is taken verbatim.

## Timing
- Reset values (first edge with `resetn`=0):
  - `pc` = RESET_PC.
  - `ram_ena`, `ram_wena`, `ld_ready`, `if_flush`, `running` = 0.
  - `ram_indata` = 0.
  - State = IDLE.
- Reset mid-LOAD aborts the load; words already written stay in RAM.
- `ram_ena`, `ram_wena`, `ram_indata`, `ld_ready`, `if_flush` and `running` are combinational from state and inputs. `pc` and state are registered.
- Load throughput is one word per cycle; the first beat can occur in the cycle after the IDLE->LOAD edge.
- RUN: `pc` updates on every non-stalled, non-halted edge, giving one fetch per cycle.
- `if_flush` is high in the same cycle as the redirect and affects the IF/ID capture at that edge.
- The cycle that enters RUN from LOAD fetches RESET_PC with no flush.

## Configuration
- `PIPE_IF_CTRL_DELAY_SLOT_EN`:
  - Defined: MIPS branch delay slot is honoured. `if_flush` is tied 0, and the instruction fetched behind a branch executes.
  - Undefined: on a redirect, `if_flush` asserts as described under RUN and squashes the wrong-path instruction.
  - All other behaviour is identical.

## Test plan
- Reset then load: `boot_req`, then 3 beats of 0x11111111/0x22222222/0x33333333, `ld_last` on the 3rd -> writes to addresses 0, 1, 2 with `ram_wena`=1 on exactly 3 cycles; next cycle state is RUN, `pc`=0, `running`=1.
- Load wrap: 32 beats with no `ld_last` -> after the beat at address 31, state is RUN and `pc`=RESET_PC.
- Stall then sequential: RUN with `npc`=`pc`+4, `stall`=1 for 2 cycles -> `pc` is held and `ram_ena`=0 for those 2 cycles; `pc` then resumes 0, 4, 8.
- Branch redirect: `pcsource`=2'b10, `npc`=0x40 -> next `pc`=0x40. `if_flush`=1 for one cycle (0 with `PIPE_IF_CTRL_DELAY_SLOT_EN`). With `stall`=1 in the same cycle, `pc` is held and `if_flush`=0.
- Halt/reboot: `halt_req` at `pc`=0x8 -> `pc` stays 0x8 and `ram_ena`=0. `boot_req` together with `resume` -> LOAD with `pc`=0.
- Mid-load reset: `resetn`=0 after 2 beats -> IDLE, `pc`=0, `ld_ready`=0 on the next cycle.

Source files
------------

// File: rtl/pipe_if_ctrl.sv
// pipe_if_ctrl: fetch-stage controller for the pipelined MIPS core.
// Owns the PC register and the single instruction-RAM port. That port is
// shared between the boot-time program loader (writes) and instruction
// fetch (reads). The controller also sequences PC updates
// (stall / redirect / halt) and raises the IF/ID flush on redirects.
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   boot_req                        (re)load program request (IDLE/HALT)
//   ld_valid, ld_data, ld_last      loader word stream
//   ld_ready                        loader word accepted (LOAD state)
//   npc, pcsource                   next PC and its select from ID
//   stall, halt_req, resume         hazard hold, stop fetch, leave HALT
//   pc                              PC register / RAM address during load
//   ram_ena, ram_wena, ram_indata   instruction RAM port controls
//   if_flush                        squash IF/ID on a redirect
//   running                         state is RUN
//
// Build option: define PIPE_IF_CTRL_DELAY_SLOT_EN to honour the MIPS
// branch delay slot (if_flush tied low).
module pipe_if_ctrl #(
   parameter int          DEPTH_LOG2 = 5,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        boot_req,
   input  logic        ld_valid,
   input  logic [31:0] ld_data,
   input  logic        ld_last,
   output logic        ld_ready,
   input  logic [31:0] npc,
   input  logic [1:0]  pcsource,
   input  logic        stall,
   input  logic        halt_req,
   input  logic        resume,
   output logic [31:0] pc,
   output logic        ram_ena,
   output logic        ram_wena,
   output logic [31:0] ram_indata,
   output logic        if_flush,
   output logic        running
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        beat;
   logic        last_addr;
   logic        redirect;

   assign pc = pc_q;

   // Final RAM word reached: the load ends here even without ld_last.
   assign last_addr = &pc_q[DEPTH_LOG2+1:2];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ld_ready   = 1'b0;
      ram_ena    = 1'b0;
      ram_wena   = 1'b0;
      ram_indata = '0;
      redirect   = 1'b0;
      running    = 1'b0;
      beat       = 1'b0;
      case (state_q)
         IDLE: begin
            pc_d = RESET_PC;
            if (boot_req) state_d = LOAD;
         end
         LOAD: begin
            ld_ready = 1'b1;
            beat     = ld_valid;
            if (beat) begin
               ram_ena    = 1'b1;
               ram_wena   = 1'b1;
               ram_indata = ld_data;
               if (ld_last || last_addr) begin
                  pc_d    = RESET_PC;
                  state_d = RUN;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
            end
         end
         RUN: begin
            running = 1'b1;
            ram_ena = ~stall;
            if (halt_req) begin
               state_d = HALT;
            end else if (!stall) begin
               pc_d = npc;
               // A stalled branch is re-presented by ID next cycle, so
               // only an unstalled redirect squashes the wrong-path fetch.
               redirect = (pcsource != 2'b00);
            end
         end
         HALT: begin
            if (boot_req) begin
               pc_d    = RESET_PC;
               state_d = LOAD;
            end else if (resume) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef PIPE_IF_CTRL_DELAY_SLOT_EN
   // Delay-slot instruction behind the branch executes; never squash.
   assign if_flush = 1'b0;
   logic unused_redirect;
   assign unused_redirect = redirect;
`else
   assign if_flush = redirect;
`endif

endmodule

// File: tb/tb_pipe_if_ctrl.sv
module tb_pipe_if_ctrl;

   logic        clk = 1'b0;
   logic        resetn, boot_req, ld_valid, ld_last, stall, halt_req, resume;
   logic [31:0] ld_data, npc;
   logic [1:0]  pcsource;
   logic        ld_ready, ram_ena, ram_wena, if_flush, running;
   logic [31:0] pc, ram_indata;

`ifdef PIPE_IF_CTRL_DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   pipe_if_ctrl #(.DEPTH_LOG2(5), .RESET_PC(32'h0)) dut (
      .clk(clk), .resetn(resetn), .boot_req(boot_req), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .npc(npc),
      .pcsource(pcsource), .stall(stall), .halt_req(halt_req), .resume(resume),
      .pc(pc), .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_indata(ram_indata),
      .if_flush(if_flush), .running(running)
   );

   always #5 clk = ~clk;

   // One record per clock: inputs driven before the edge, expected values
   // are those observed in that cycle (pc is the register value).
   typedef struct {
      logic        rst_n, boot, vld, last, stl, hlt, res;
      logic [31:0] dat, npc;
      logic [1:0]  psrc;
      logic [31:0] e_pc, e_dat;
      logic        e_ena, e_wena, e_rdy, e_flush, e_run;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic rst_n, boot, vld, input logic [31:0] dat,
                      input logic last, input logic [31:0] n, input logic [1:0] ps,
                      input logic stl, hlt, res, input logic [31:0] e_pc,
                      input logic e_ena, e_wena, input logic [31:0] e_dat,
                      input logic e_rdy, e_flush, e_run);
      vec_t v;
      v.rst_n = rst_n; v.boot = boot; v.vld = vld; v.dat = dat; v.last = last;
      v.npc = n; v.psrc = ps; v.stl = stl; v.hlt = hlt; v.res = res;
      v.e_pc = e_pc; v.e_ena = e_ena; v.e_wena = e_wena; v.e_dat = e_dat;
      v.e_rdy = e_rdy; v.e_flush = e_flush & ~DS; v.e_run = e_run;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      resetn = v.rst_n; boot_req = v.boot; ld_valid = v.vld; ld_data = v.dat;
      ld_last = v.last; npc = v.npc; pcsource = v.psrc; stall = v.stl;
      halt_req = v.hlt; resume = v.res;
   endtask

   initial begin
      //   rst boot vld data          last npc        ps    stl hlt res | pc  ena wena data rdy fl run
      add(1, 0, 0, 32'h0,        0, 32'h0,  2'b00, 0, 0, 0,  32'h0,  0, 0, 32'h0,        0, 0, 0); // IDLE
      add(1, 1, 0, 32'h0,        0, 32'h0,  2'b00, 0, 0, 0,  32'h0,  0, 0, 32'h0,        0, 0, 0); // boot
      add(1, 0, 0, 32'h0,        0, 32'h0,  2'b00, 0, 0, 0,  32'h0,  0, 0, 32'h0,        1, 0, 0); // LOAD idle
      add(1, 0, 1, 32'h11111111, 0, 32'h0,  2'b00, 0, 0, 0,  32'h0,  1, 1, 32'h11111111, 1, 0, 0);
      add(1, 0, 1, 32'h22222222, 0, 32'h0,  2'b00, 0, 0, 0,  32'h4,  1, 1, 32'h22222222, 1, 0, 0);
      add(1, 0, 1, 32'h33333333, 1, 32'h0,  2'b00, 0, 0, 0,  32'h8,  1, 1, 32'h33333333, 1, 0, 0);
      add(1, 0, 1, 32'h44444444, 0, 32'h4,  2'b00, 0, 0, 0,  32'h0,  1, 0, 32'h0,        0, 0, 1); // RUN, no write
      add(1, 0, 0, 32'h0,        0, 32'h8,  2'b00, 1, 0, 0,  32'h4,  0, 0, 32'h0,        0, 0, 1); // stall
      add(1, 0, 0, 32'h0,        0, 32'h8,  2'b00, 1, 0, 0,  32'h4,  0, 0, 32'h0,        0, 0, 1); // stall
      add(1, 0, 0, 32'h0,        0, 32'h8,  2'b00, 0, 0, 0,  32'h4,  1, 0, 32'h0,        0, 0, 1);
      add(1, 0, 0, 32'h0,        0, 32'h40, 2'b10, 1, 0, 0,  32'h8,  0, 0, 32'h0,        0, 0, 1); // stalled branch
      add(1, 0, 0, 32'h0,        0, 32'h40, 2'b10, 0, 0, 0,  32'h8,  1, 0, 32'h0,        0, 1, 1); // redirect
      add(1, 0, 0, 32'h0,        0, 32'h44, 2'b00, 0, 0, 0,  32'h40, 1, 0, 32'h0,        0, 0, 1);
      add(1, 0, 0, 32'h0,        0, 32'h8,  2'b01, 0, 0, 0,  32'h44, 1, 0, 32'h0,        0, 1, 1); // redirect to 8
      add(1, 0, 0, 32'h0,        0, 32'hC,  2'b00, 0, 1, 0,  32'h8,  1, 0, 32'h0,        0, 0, 1); // halt
      add(1, 0, 0, 32'h0,        0, 32'hC,  2'b00, 0, 0, 0,  32'h8,  0, 0, 32'h0,        0, 0, 0); // HALT
      add(1, 0, 0, 32'h0,        0, 32'hC,  2'b00, 0, 0, 0,  32'h8,  0, 0, 32'h0,        0, 0, 0);
      add(1, 1, 0, 32'h0,        0, 32'hC,  2'b00, 0, 0, 1,  32'h8,  0, 0, 32'h0,        0, 0, 0); // boot+resume
      add(1, 0, 1, 32'hA5A5A5A5, 0, 32'h0,  2'b00, 0, 0, 0,  32'h0,  1, 1, 32'hA5A5A5A5, 1, 0, 0); // LOAD pc=0
      add(1, 0, 1, 32'h5A5A5A5A, 0, 32'h0,  2'b00, 0, 0, 0,  32'h4,  1, 1, 32'h5A5A5A5A, 1, 0, 0);
      add(0, 0, 0, 32'h0,        0, 32'h0,  2'b00, 0, 0, 0,  32'h8,  0, 0, 32'h0,        1, 0, 0); // reset mid-load
      add(1, 0, 0, 32'h0,        0, 32'h0,  2'b00, 0, 0, 0,  32'h0,  0, 0, 32'h0,        0, 0, 0); // IDLE
      add(1, 1, 0, 32'h0,        0, 32'h0,  2'b00, 0, 0, 0,  32'h0,  0, 0, 32'h0,        0, 0, 0); // boot
      // 32 beats with no ld_last: wraps to RUN after address 31.
      for (int i = 0; i < 32; i++)
         add(1, 0, 1, 32'hC000_0000 + i, 0, 32'h0, 2'b00, 0, 0, 0,
             32'(i * 4), 1, 1, 32'hC000_0000 + i, 1, 0, 0);
      add(1, 0, 0, 32'h0,        0, 32'h40, 2'b10, 1, 1, 0,  32'h0,  0, 0, 32'h0,        0, 0, 1); // halt beats stall/branch
      add(1, 0, 0, 32'h0,        0, 32'h40, 2'b00, 0, 0, 1,  32'h0,  0, 0, 32'h0,        0, 0, 0); // resume
      add(1, 0, 0, 32'h0,        0, 32'h10, 2'b00, 0, 0, 0,  32'h0,  1, 0, 32'h0,        0, 0, 1);
      add(1, 0, 0, 32'h0,        0, 32'h14, 2'b00, 0, 0, 0,  32'h10, 1, 0, 32'h0,        0, 0, 1);

      // Reset sequence, then check the reset state.
      resetn = 0; boot_req = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
      npc = 0; pcsource = 0; stall = 0; halt_req = 0; resume = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset_pc",       -1, pc, 32'h0);
      chk("reset_ram_ena",  -1, 32'(ram_ena), 32'h0);
      chk("reset_ram_wena", -1, 32'(ram_wena), 32'h0);
      chk("reset_ld_ready", -1, 32'(ld_ready), 32'h0);
      chk("reset_if_flush", -1, 32'(if_flush), 32'h0);
      chk("reset_running",  -1, 32'(running), 32'h0);
      chk("reset_indata",   -1, ram_indata, 32'h0);

      foreach (vecs[i]) begin
         drive(vecs[i]);
         #1;
         chk("pc",         i, pc, vecs[i].e_pc);
         chk("ram_ena",    i, 32'(ram_ena), 32'(vecs[i].e_ena));
         chk("ram_wena",   i, 32'(ram_wena), 32'(vecs[i].e_wena));
         chk("ram_indata", i, ram_indata, vecs[i].e_dat);
         chk("ld_ready",   i, 32'(ld_ready), 32'(vecs[i].e_rdy));
         chk("if_flush",   i, 32'(if_flush), 32'(vecs[i].e_flush));
         chk("running",    i, 32'(running), 32'(vecs[i].e_run));
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
